// File: rtl/regslice_depth_n.sv
// Elastic register slice with a Depth-entry circular buffer and occupancy output.
// Define REGSLICE_DEPTH_N_STALL_CNT_EN to add the saturating stall_cnt output.
module regslice_depth_n #(
   parameter int DataWidth = 32,
   parameter int Depth     = 4,
   localparam int CntW     = $clog2(Depth + 1)
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic [DataWidth-1:0] data_in,
   input  logic                 vld_in,
   output logic                 ack_in,
   output logic [DataWidth-1:0] data_out,
   output logic                 vld_out,
   input  logic                 ack_out,
   output logic [CntW-1:0]      occupancy,
`ifdef REGSLICE_DEPTH_N_STALL_CNT_EN
   output logic [15:0]          stall_cnt,
`endif
   output logic                 apdone_blk
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW-1:0] PTR_LAST = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] CNT_FULL = CntW'(Depth);

   if (Depth < 2) begin : g_depth_chk
      $error("regslice_depth_n: Depth must be at least 2");
   end

   logic [DataWidth-1:0] mem_q [Depth];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      occ_q, occ_d;
   logic                 push, pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PtrW'(1);
   endfunction

   // Full never accepts, so ack_in depends only on registered state and reset.
   assign ack_in     = ~ap_rst & (occ_q != CNT_FULL);
   assign vld_out    = (occ_q != '0);
   assign data_out   = mem_q[rd_ptr_q];
   assign occupancy  = occ_q;
   assign push       = vld_in & ack_in;
   assign pop        = vld_out & ack_out;
   assign apdone_blk = ~ap_rst & ((occ_q >= CntW'(2)) | ((occ_q == CntW'(1)) & ~ack_out));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
         2'b10:   occ_d = occ_q + CntW'(1);
         2'b01:   occ_d = occ_q - CntW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   for (genvar gi = 0; gi < Depth; gi++) begin : g_mem
      always_ff @(posedge ap_clk) begin
         if (ap_rst)
            mem_q[gi] <= '0;
         else if (push && (wr_ptr_q == PtrW'(gi)))
            mem_q[gi] <= data_in;
      end
   end

`ifdef REGSLICE_DEPTH_N_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        stall;

   // Both stall sources together still advance the count by one.
   assign stall = (vld_out & ~ack_out) | (vld_in & ~ack_in & ~ap_rst);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regslice_depth_n.sv
// Directed bench for regslice_depth_n: Depth=4 and Depth=3 instances share stimulus,
// each checked every cycle against a queue model plus literal expectations.
module tb_regslice_depth_n;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = '0;
   logic       vld_in = 1'b0;
   logic       ack_out = 1'b0;

   logic       ack_in4, vld_out4, apdone4;
   logic [7:0] data_out4;
   logic [2:0] occ4;
   logic       ack_in3, vld_out3, apdone3;
   logic [7:0] data_out3;
   logic [1:0] occ3;
`ifdef REGSLICE_DEPTH_N_STALL_CNT_EN
   logic [15:0] stall4, stall3;
`endif

   int checks = 0;
   int passed = 0;
   int src_idx = 0;

   always #5 clk = ~clk;

   regslice_depth_n #(.DataWidth(8), .Depth(4)) dut4 (
      .ap_clk(clk), .ap_rst(rst), .data_in(data_in), .vld_in(vld_in), .ack_in(ack_in4),
      .data_out(data_out4), .vld_out(vld_out4), .ack_out(ack_out), .occupancy(occ4),
`ifdef REGSLICE_DEPTH_N_STALL_CNT_EN
      .stall_cnt(stall4),
`endif
      .apdone_blk(apdone4));

   regslice_depth_n #(.DataWidth(8), .Depth(3)) dut3 (
      .ap_clk(clk), .ap_rst(rst), .data_in(data_in), .vld_in(vld_in), .ack_in(ack_in3),
      .data_out(data_out3), .vld_out(vld_out3), .ack_out(ack_out), .occupancy(occ3),
`ifdef REGSLICE_DEPTH_N_STALL_CNT_EN
      .stall_cnt(stall3),
`endif
      .apdone_blk(apdone3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      else
         passed++;
   endtask

   // Reference model: each slice is an ordered queue of accepted beats.
   logic [7:0] q4[$];
   logic [7:0] q3[$];
   logic [7:0] rx4[$];
   logic [7:0] rx3[$];
   bit         wrote4 = 0, wrote3 = 0, started = 0;

   always @(posedge clk) begin : model
      bit a4, a3, p4, p3;
      started <= 1'b1;
      if (vld_out4 && ack_out) rx4.push_back(data_out4);
      if (vld_out3 && ack_out) rx3.push_back(data_out3);
      if (rst) begin
         q4.delete();
         q3.delete();
         wrote4 <= 1'b0;
         wrote3 <= 1'b0;
      end else begin
         a4 = vld_in && (q4.size() != 4);
         a3 = vld_in && (q3.size() != 3);
         p4 = (q4.size() != 0) && ack_out;
         p3 = (q3.size() != 0) && ack_out;
         if (p4) void'(q4.pop_front());
         if (p3) void'(q3.pop_front());
         if (a4) begin q4.push_back(data_in); wrote4 <= 1'b1; end
         if (a3) begin q3.push_back(data_in); wrote3 <= 1'b1; end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m4_vld", 32'(vld_out4), 32'(q4.size() != 0));
         chk("m4_occ", 32'(occ4), 32'(q4.size()));
         chk("m4_ack", 32'(ack_in4), 32'(!rst && q4.size() != 4));
         chk("m4_apdone", 32'(apdone4),
             32'(!rst && (q4.size() >= 2 || (q4.size() == 1 && !ack_out))));
         if (q4.size() != 0) chk("m4_data", 32'(data_out4), 32'(q4[0]));
         else if (!wrote4)   chk("m4_data0", 32'(data_out4), 32'h0);
         chk("m3_vld", 32'(vld_out3), 32'(q3.size() != 0));
         chk("m3_occ", 32'(occ3), 32'(q3.size()));
         chk("m3_ack", 32'(ack_in3), 32'(!rst && q3.size() != 3));
         chk("m3_apdone", 32'(apdone3),
             32'(!rst && (q3.size() >= 2 || (q3.size() == 1 && !ack_out))));
         if (q3.size() != 0) chk("m3_data", 32'(data_out3), 32'(q3[0]));
         else if (!wrote3)   chk("m3_data0", 32'(data_out3), 32'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Source obeying the handshake of the Depth=4 instance.
   task automatic src_cycles(input logic [7:0] base, input int total, input int ncyc);
      bit acc;
      for (int c = 0; c < ncyc && src_idx < total; c++) begin
         data_in = base + 8'(src_idx);
         vld_in  = 1'b1;
         mid();
         acc = ack_in4;
         tick();
         if (acc) src_idx++;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      vld_in  = 1'b0;
      ack_out = 1'b1;
      while ((occ4 != 0 || occ3 != 0) && n < 30) begin
         tick();
         n++;
      end
      chk({name, "_drain_timeout"}, 32'(n < 30), 32'd1);
   endtask

   task automatic chk_rx(input string name, input logic [7:0] base, input int n);
      chk({name, "_rx4_len"}, 32'(rx4.size()), 32'(n));
      chk({name, "_rx3_len"}, 32'(rx3.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < rx4.size()) chk({name, "_rx4"}, 32'(rx4[i]), 32'(base + 8'(i)));
         if (i < rx3.size()) chk({name, "_rx3"}, 32'(rx3[i]), 32'(base + 8'(i)));
      end
   endtask

   initial begin
      // 1. Reset with upstream offering 8'h55
      rst = 1'b1; vld_in = 1'b1; data_in = 8'h55; ack_out = 1'b1;
      tick();
      repeat (3) begin
         mid();
         chk("rst_ack_in", 32'(ack_in4), 32'h0);
         chk("rst_vld_out", 32'(vld_out4), 32'h0);
         chk("rst_data_out", 32'(data_out4), 32'h0);
         chk("rst_occ", 32'(occ4), 32'h0);
         chk("rst_apdone", 32'(apdone4), 32'h0);
         tick();
      end
      rst = 1'b0;
      mid();
      chk("rel_ack_in", 32'(ack_in4), 32'h1);
      tick();
      vld_in = 1'b0;
      mid();
      chk("rel_vld_out", 32'(vld_out4), 32'h1);
      chk("rel_data_out", 32'(data_out4), 32'h55);
      tick();
      tick();

      // 2. Streaming 01..10 with ack_out high
      rx4.delete(); rx3.delete();
      ack_out = 1'b1;
      mid();
      chk("s_empty_vld", 32'(vld_out4), 32'h0);
      for (int i = 1; i <= 16; i++) begin
         data_in = 8'(i);
         vld_in  = 1'b1;
         tick();
         if (i == 1) begin mid(); chk("s_latency_vld", 32'(vld_out4), 32'h1); end
         if (i == 8) begin
            mid();
            chk("s_occ_steady", 32'(occ4), 32'h1);
            chk("s_apdone_steady", 32'(apdone4), 32'h0);
         end
      end
      drain("stream");
      chk_rx("stream", 8'h01, 16);

      // 3. Fill under backpressure, then release
      rx4.delete(); rx3.delete();
      ack_out = 1'b0; src_idx = 0;
      src_cycles(8'hA0, 6, 8);
      chk("f_accepted", 32'(src_idx), 32'd4);
      mid();
      chk("f_occ", 32'(occ4), 32'd4);
      chk("f_ack_in", 32'(ack_in4), 32'h0);
      chk("f_apdone", 32'(apdone4), 32'h1);
      chk("f_head", 32'(data_out4), 32'hA0);
      tick();
      mid();
      chk("f_head_stable", 32'(data_out4), 32'hA0);
      ack_out = 1'b1;
      src_cycles(8'hA0, 6, 20);
      chk("f_src_done", 32'(src_idx), 32'd6);
      drain("fill");
      chk("f_rx4_len", 32'(rx4.size()), 32'd6);
      for (int i = 0; i < 6 && i < rx4.size(); i++)
         chk("f_rx4", 32'(rx4[i]), 32'(8'hA0 + 8'(i)));

      // 4. Simultaneous push/pop at occupancy 2, pointers wrap in both depths
      tick();
      rx4.delete(); rx3.delete();
      ack_out = 1'b0; src_idx = 0;
      src_cycles(8'hB0, 2, 4);
      ack_out = 1'b1;
      for (int k = 0; k < 6; k++) begin
         data_in = 8'hB2 + 8'(k);
         vld_in  = 1'b1;
         tick();
         mid();
         chk("pp_occ4", 32'(occ4), 32'd2);
         chk("pp_occ3", 32'(occ3), 32'd2);
      end
      drain("pushpop");
      chk_rx("pushpop", 8'hB0, 8);

      // 5. Reset with three entries held
      tick();
      rx4.delete(); rx3.delete();
      ack_out = 1'b0; src_idx = 0;
      src_cycles(8'hC0, 3, 5);
      vld_in = 1'b0;
      mid();
      chk("mr_occ_before", 32'(occ4), 32'd3);
      rst = 1'b1; vld_in = 1'b1; data_in = 8'hC3;
      mid();
      chk("mr_ack_in_rst", 32'(ack_in4), 32'h0);
      tick();
      rst = 1'b0; vld_in = 1'b0; ack_out = 1'b1;
      mid();
      chk("mr_occ", 32'(occ4), 32'h0);
      chk("mr_vld_out", 32'(vld_out4), 32'h0);
      chk("mr_data_out", 32'(data_out4), 32'h0);
      chk("mr_ack_in", 32'(ack_in4), 32'h1);
      chk("mr_occ3", 32'(occ3), 32'h0);
      repeat (5) tick();
      chk("mr_no_stale4", 32'(rx4.size()), 32'd0);
      chk("mr_no_stale3", 32'(rx3.size()), 32'd0);

`ifdef REGSLICE_DEPTH_N_STALL_CNT_EN
      // 6. Stall counter: starts after the first beat lands, then saturates
      chk("sc_zero", 32'(stall4), 32'h0);
      ack_out = 1'b0; vld_in = 1'b1; data_in = 8'hD0;
      repeat (10) tick();
      chk("sc_ten", 32'(stall4), 32'd9);
      repeat (70000) tick();
      chk("sc_sat", 32'(stall4), 32'hFFFF);
      chk("sc_sat3", 32'(stall3), 32'hFFFF);
      rst = 1'b1;
      tick();
      chk("sc_clear", 32'(stall4), 32'h0);
      rst = 1'b0; vld_in = 1'b0;
      tick();
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/regslice_depth_n.md
Name: regslice_depth_n

Overview:
- Parametrised-depth successor to the two-entry HLS register slice.
- Circular-buffer elastic stage with configurable DataWidth and Depth, and an exported occupancy count.
- apdone_blk tells the HLS scheduler that data will remain after the current cycle.
- Sits on AXI-Stream-style vld/ack channels between HLS cores and DFX boundary logic, where more than two entries of slack are needed.

Parameters:
- DataWidth, 32, payload width in bits (>=1).
- Depth, 4, number of storage entries. Must be >=2; Depth<2 is an elaboration error. Need not be a power of two.
- CntW, $clog2(Depth+1), occupancy width (localparam, not overridable).

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- data_in  in  DataWidth  upstream payload.
- vld_in  in  1  upstream valid.
- ack_in  out  1  upstream ready.
- data_out  out  DataWidth  downstream payload (head entry).
- vld_out  out  1  downstream valid.
- ack_out  in  1  downstream ready.
- occupancy  out  CntW  entries currently held, 0..Depth.
- apdone_blk  out  1  slice will still hold data after this cycle.

Behaviour:
- Storage: Depth x DataWidth array, wr_ptr, rd_ptr (0..Depth-1), occupancy register.
- Pointer wrap: each pointer increments modulo Depth; Depth-1 -> 0, including non-power-of-two Depth.
- push = vld_in & ack_in. pop = vld_out & ack_out.
- push writes mem[wr_ptr]. pop advances rd_ptr.
- occupancy: push only -> +1; pop only -> -1; both -> unchanged.
- ack_in = ~ap_rst & (occupancy != Depth).
  - Low during reset.
  - No combinational path from ack_out.
  - Full never accepts, even when a pop occurs in the same cycle.
- vld_out = (occupancy != 0). Driven from registers only; no combinational path from vld_in.
- data_out = mem[rd_ptr].
- Latency: push at cycle N -> vld_out high at N+1 (empty case).
- Throughput: 1 beat/cycle sustained when ack_out stays high.
- Ordering: strict FIFO. No drop or duplicate under any vld_in/ack_out pattern.
- Upstream contract: the source holds data_in/vld_in stable while vld_in & ~ack_in. The slice does not check this.
- Downstream guarantee: while vld_out & ~ack_out, data_out and vld_out stay stable (the head entry is never overwritten).
- apdone_blk = (occupancy >= 2) | (occupancy == 1 & ~ack_out). Forced 0 while ap_rst is high.
- Reset (any cycle, including mid-transfer):
  - Next edge: occupancy=0, wr_ptr=rd_ptr=0, all mem entries=0.
  - Resulting outputs: vld_out=0, data_out=0, apdone_blk=0.
  - ack_in=0 combinationally while ap_rst=1; ack_in=1 on the first cycle after ap_rst falls.
  - In-flight data is discarded.
- Empty + push + ack_out high: no bypass. The beat appears the next cycle.

Optional Feature:
- Macro: REGSLICE_DEPTH_N_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (out, 16).
  - Counts cycles with vld_out & ~ack_out, plus cycles with vld_in & ~ack_in while ap_rst=0.
  - Saturates at 16'hFFFF (no wrap). Cleared to 0 by ap_rst.
  - Incremented by 1 per cycle even if both conditions hold in the same cycle.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan (DataWidth=8, Depth=4 unless stated):
1. Reset: ap_rst=1 for 3 cycles with vld_in=1, data_in=8'h55 -> ack_in=0, vld_out=0, data_out=0, occupancy=0, apdone_blk=0 throughout. ack_in=1 on the first cycle after release; 8'h55 is accepted only then.
2. Stream: push 8'h01..8'h10 back-to-back with ack_out=1 -> vld_out rises 1 cycle after the first push. Outputs are 01..10 in order, one per cycle. occupancy=1 in steady state; apdone_blk=0 in steady state.
3. Fill/backpressure: ack_out=0, offer 8'hA0..8'hA5 -> A0..A3 accepted, then ack_in=0, occupancy=4, apdone_blk=1, data_out=A0 stable. Raise ack_out -> A0..A5 delivered in order with no gaps.
4. Simultaneous push/pop: with occupancy=2, push and pop together for 6 cycles -> occupancy stays 2. Pointers wrap past 3 -> 0 with order preserved. Repeat with Depth=3 to confirm wrap 2 -> 0.
5. Reset mid-operation: occupancy=3, assert ap_rst for 1 cycle -> next cycle occupancy=0, vld_out=0, data_out=0. ack_in=0 during reset, 1 after. Stale entries never reappear.
6. REGSLICE_DEPTH_N_STALL_CNT_EN: hold full with ack_out=0 and vld_in=1 for 70000 cycles -> stall_cnt saturates at 16'hFFFF. ap_rst clears it to 0.
